// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop toward requested states using its excitation table,
// then reads the flop back and counts mismatches in a saturating error counter.
module jk_excitation_driver #(
    parameter int   CNT_W   = 8,
    parameter logic DC_FILL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic             q_m, q_m_nx;
    logic             tgt, tgt_nx;
    logic             j_nx, k_nx;
    logic             chk_valid_nx, chk_pass_nx;
    logic [CNT_W-1:0] err_cnt_nx;

    // j/k are registered, so the values computed here appear during the next state.
    always_comb begin
        state_nx     = state;
        q_m_nx       = q_m;
        tgt_nx       = tgt;
        j_nx         = 1'b0;
        k_nx         = 1'b0;
        chk_valid_nx = 1'b0;
        chk_pass_nx  = chk_pass;
        err_cnt_nx   = err_cnt;
        tgt_ready    = 1'b0;
        case (state)
            INIT: begin
                state_nx = IDLE;
                q_m_nx   = 1'b0;
            end
            IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    tgt_nx   = tgt_bit;
                    state_nx = DRIVE;
                    case ({q_m, tgt_bit})
                        2'b00:   begin j_nx = 1'b0;    k_nx = DC_FILL; end
                        2'b01:   begin j_nx = 1'b1;    k_nx = DC_FILL; end
                        2'b10:   begin j_nx = DC_FILL; k_nx = 1'b1;    end
                        default: begin j_nx = DC_FILL; k_nx = 1'b0;    end
                    endcase
                end
            end
            DRIVE: begin
                state_nx = CHECK;
            end
            CHECK: begin
                // Resync the model to what the flop actually holds, pass or fail.
                state_nx     = IDLE;
                chk_valid_nx = 1'b1;
                chk_pass_nx  = (q_fb == tgt);
                q_m_nx       = q_fb;
                if ((q_fb != tgt) && (err_cnt != CNT_MAX))
                    err_cnt_nx = err_cnt + CNT_ONE;
            end
            default: begin
                state_nx = INIT;
                k_nx     = 1'b1;
            end
        endcase
        if (err_clr)
            err_cnt_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            j         <= 1'b0;
            k         <= 1'b1;
            q_m       <= 1'b0;
            tgt       <= 1'b0;
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            j         <= j_nx;
            k         <= k_nx;
            q_m       <= q_m_nx;
            tgt       <= tgt_nx;
            chk_valid <= chk_valid_nx;
            chk_pass  <= chk_pass_nx;
            err_cnt   <= err_cnt_nx;
        end
    end

endmodule
